// File: rtl/moore_pkg.sv
// Shared definitions for the 1101 Moore sequence controller: state codes,
// widths and the counter saturation value.
package moore_pkg;

    localparam int STATE_W = 3;
    localparam int COUNT_W = 4;

    localparam logic [COUNT_W-1:0] COUNT_MAX = 4'd15;

    // Codes 101, 110 and 111 are unused and recover to IDLE.
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'b000,
        G1     = 3'b001,
        G11    = 3'b010,
        G110   = 3'b011,
        DETECT = 3'b100
    } state_e;

endpackage

// File: rtl/moore_state_register.sv
// Three-bit state register for the sequence controller, cleared to IDLE
// by an asynchronous active-high reset.
module moore_state_register
    import moore_pkg::*;
(
    input  logic               inputClk,
    input  logic               inputR,
    input  logic [STATE_W-1:0] d,
    output logic [STATE_W-1:0] q
);

    // Capture the next state on each rising edge; reset forces IDLE at once.
    always_ff @(posedge inputClk or posedge inputR) begin
        if (inputR) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/moore_seq_controller.sv
// Overlapping 1101 detector on valid-qualified serial bits, with a
// saturating detection counter and a sticky overflow flag.
module moore_seq_controller
    import moore_pkg::*;
(
    input  logic               inputClk,
    input  logic               inputR,
    input  logic               inputX,
    input  logic               inputValid,
    input  logic               inputClear,
    output logic               outputZ,
    output logic [STATE_W-1:0] outputState,
    output logic [COUNT_W-1:0] outputCount,
    output logic               outputOverflow
);

    logic [STATE_W-1:0] stateQ;
    wire  [STATE_W-1:0] stateNext;
    logic               detectEvent;

    // Unused codes recover to IDLE whatever the inputs; legal states hold
    // while no valid bit is offered.
    function automatic logic [STATE_W-1:0] computeNext(
        input logic [STATE_W-1:0] cur,
        input logic               x,
        input logic               v
    );
        logic [STATE_W-1:0] nxt;
        nxt = IDLE;
        case (cur)
            IDLE:    nxt = v ? (x ? G1     : IDLE) : cur;
            G1:      nxt = v ? (x ? G11    : IDLE) : cur;
            G11:     nxt = v ? (x ? G11    : G110) : cur;
            G110:    nxt = v ? (x ? DETECT : IDLE) : cur;
            DETECT:  nxt = v ? (x ? G11    : IDLE) : cur;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    assign stateNext = computeNext(stateQ, inputX, inputValid);

    moore_state_register stateReg (
        .inputClk (inputClk),
        .inputR   (inputR),
        .d        (stateNext),
        .q        (stateQ)
    );

    // A detection is the G110 -> DETECT step, seen one cycle early so the
    // count updates on the same edge that raises outputZ.
    assign detectEvent = (stateQ == G110) && (stateNext == DETECT);

    assign outputState = stateQ;
    assign outputZ     = (stateQ == DETECT);

    // Detection counter: clear wins over a coincident detection, and a
    // detection at the ceiling leaves the count alone but flags overflow.
    always_ff @(posedge inputClk or posedge inputR) begin
        if (inputR) begin
            outputCount    <= '0;
            outputOverflow <= 1'b0;
        end else if (inputClear) begin
            outputCount    <= '0;
            outputOverflow <= 1'b0;
        end else if (detectEvent) begin
            if (outputCount == COUNT_MAX) begin
                outputOverflow <= 1'b1;
            end else begin
                outputCount <= outputCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_moore_seq_controller.sv
// Randomised and directed bench for moore_seq_controller, checked against a
// bit-history model of the 1101 detector through a scoreboard queue.
module tb_moore_seq_controller;

    logic       clk;
    logic       rst;
    logic       inputX;
    logic       inputValid;
    logic       inputClear;
    logic       outputZ;
    logic [2:0] outputState;
    logic [3:0] outputCount;
    logic       outputOverflow;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       z;
        logic [3:0] cnt;
        logic       ovf;
    } expect_t;

    expect_t expQ[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: recent valid bits, how many since reset, and counters.
    int histBits = 0;
    int histLen  = 0;
    int modelCnt = 0;
    bit modelOvf = 0;

    moore_seq_controller dut (
        .inputClk       (clk),
        .inputR         (rst),
        .inputX         (inputX),
        .inputValid     (inputValid),
        .inputClear     (inputClear),
        .outputZ        (outputZ),
        .outputState    (outputState),
        .outputCount    (outputCount),
        .outputOverflow (outputOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Longest suffix of the received bits that is a prefix of 1101 picks the
    // state; a full 1101 suffix is DETECT.
    function automatic logic [2:0] modelState(input int h, input int n);
        if (n >= 4 && (h & 15) == 13) return 3'd4;
        if (n >= 3 && (h & 7) == 6)   return 3'd3;
        if (n >= 2 && (h & 3) == 3)   return 3'd2;
        if (n >= 1 && (h & 1) == 1)   return 3'd1;
        return 3'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [2:0] st, input logic z,
                               input logic [3:0] cnt, input logic ovf);
        checks++;
        if (outputState !== st || outputZ !== z || outputCount !== cnt || outputOverflow !== ovf) begin
            failures++;
            $display("[TB] FAIL %s: got state=%b z=%b count=%0d ovf=%b, expected state=%b z=%b count=%0d ovf=%b",
                     tag, outputState, outputZ, outputCount, outputOverflow, st, z, cnt, ovf);
        end
    endtask

    // Drive one cycle of inputs, advance the model and queue what the DUT
    // must show after the following rising edge.
    task automatic applyStimulus(input string tag, input bit x, input bit v, input bit clr);
        expect_t e;
        bit detect;
        @(negedge clk);
        inputX     = x;
        inputValid = v;
        inputClear = clr;
        detect = 0;
        if (v) begin
            histBits = ((histBits << 1) | int'(x)) & 15;
            if (histLen < 4) histLen++;
            detect = (modelState(histBits, histLen) == 3'd4);
        end
        if (clr) begin
            modelCnt = 0;
            modelOvf = 0;
        end else if (detect) begin
            if (modelCnt == 15) modelOvf = 1;
            else modelCnt++;
        end
        e.tag = tag;
        e.st  = modelState(histBits, histLen);
        e.z   = (e.st == 3'd4);
        e.cnt = 4'(modelCnt);
        e.ovf = modelOvf;
        expQ.push_back(e);
    endtask

    task automatic sendBits(input string tag, input bit [3:0] bits);
        for (int i = 3; i >= 0; i--) applyStimulus(tag, bits[i], 1'b1, 1'b0);
    endtask

    // Assert reset between edges, confirm its immediate effect, hold it over
    // an edge with a live-looking input, then release.
    task automatic doReset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        histBits = 0;
        histLen  = 0;
        modelCnt = 0;
        modelOvf = 0;
        checkOutput({tag, "_async"}, 3'd0, 1'b0, 4'd0, 1'b0);
        inputX     = 1'b1;
        inputValid = 1'b1;
        inputClear = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_held"}, 3'd0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        rst        = 1'b0;
        inputValid = 1'b0;
    endtask

    // Monitor: outputs settle one step after each edge; pop and compare
    // whenever a response is outstanding.
    initial begin : monitor
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput(e.tag, e.st, e.z, e.cnt, e.ovf);
            end
        end
    end

    initial begin : stimulus
        int waitCycles;
        rst        = 1'b1;
        inputX     = 1'b0;
        inputValid = 1'b0;
        inputClear = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        doReset("reset");

        // Overlapping detection 1101101.
        sendBits("overlap_a", 4'b1101);
        applyStimulus("overlap_b", 1'b1, 1'b1, 1'b0);
        applyStimulus("overlap_b", 1'b0, 1'b1, 1'b0);
        applyStimulus("overlap_b", 1'b1, 1'b1, 1'b0);
        applyStimulus("detect_hold", 1'b0, 1'b0, 1'b0);
        applyStimulus("detect_hold", 1'b1, 1'b0, 1'b0);

        // Stall mid-pattern with inputX toggling.
        applyStimulus("clear0", 1'b0, 1'b0, 1'b1);
        applyStimulus("idle", 1'b0, 1'b1, 1'b0);
        applyStimulus("stall_pre", 1'b1, 1'b1, 1'b0);
        applyStimulus("stall_pre", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("stall", 1'(i), 1'b0, 1'b0);
        applyStimulus("stall_post", 1'b0, 1'b1, 1'b0);
        applyStimulus("stall_post", 1'b1, 1'b1, 1'b0);

        // Saturation: 16 detections from zero, a 17th, then a clear.
        applyStimulus("sat_clear", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) sendBits("saturate", 4'b1101);
        applyStimulus("sat_hold", 1'b0, 1'b0, 1'b0);
        applyStimulus("sat_clear2", 1'b0, 1'b0, 1'b1);

        // Clear coinciding with the completing bit.
        applyStimulus("collide", 1'b1, 1'b1, 1'b0);
        applyStimulus("collide", 1'b1, 1'b1, 1'b0);
        applyStimulus("collide", 1'b0, 1'b1, 1'b0);
        applyStimulus("collide_clr", 1'b1, 1'b1, 1'b1);

        // Random traffic with occasional mid-stream resets.
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) doReset("rand_reset");
            applyStimulus("random", 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
        end

        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d responses outstanding, expected 0", expQ.size());
        end

        // Unused code 110 recovers to IDLE with no valid input.
        @(negedge clk);
        inputValid = 1'b0;
        inputClear = 1'b0;
        force dut.stateNext = 3'b110;
        @(posedge clk);
        #1;
        checkOutput("illegal_load", 3'b110, 1'b0, 4'(modelCnt), modelOvf);
        release dut.stateNext;
        inputX = ~inputX;
        @(posedge clk);
        #1;
        checkOutput("illegal_recover", 3'b000, 1'b0, 4'(modelCnt), modelOvf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
